// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioner.
//   DEBOUNCE_DEFAULT : default stable-sample count (5 ms at 36 MHz)
//   cnt_w()          : debounce counter width, $clog2 with a floor of 1
package button_pkg;

  localparam int DEBOUNCE_DEFAULT = 180000;

  function automatic int cnt_w(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: polarity normalisation, two-flop synchroniser,
// debounce counter, stable state and single-cycle press/release strobes.
// Ports:
//   clk        in   PLL clock
//   reset_n    in   async active-low reset
//   pin_i      in   raw pin, asynchronous to clk
//   level_o    out  debounced level, 1 = pressed
//   pressed_o  out  one-cycle strobe when level_o goes 0->1
//   released_o out  one-cycle strobe when level_o goes 1->0
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o,
  output logic pressed_o,
  output logic released_o
);

  localparam int                CNT_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             raw;
  logic             s;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             st_q, st_d;
  logic             pressed_q, pressed_d;
  logic             released_q, released_d;

  // Inverting before the synchroniser keeps the reset value (0) meaning
  // "released" regardless of pin polarity.
  assign raw = pin_i ^ ACTIVE_LOW;
  assign s   = sync_q[1];

  // Any sample matching the stable state restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples flips st.
  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    if (s != st_q) begin
      if (cnt_q == CNT_LAST) begin
        st_d  = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    pressed_d  = ~st_q &  st_d;
    released_d =  st_q & ~st_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      st_q       <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], raw};
      cnt_q      <= cnt_d;
      st_q       <= st_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign level_o    = st_q;
  assign pressed_o  = pressed_q;
  assign released_o = released_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw push-button pins for the core: per-channel debounce,
// press/release strobes, sticky per-button event mask and combined irq.
// Ports:
//   clk            in   PLL clock, the only clock
//   reset_n        in   async active-low reset
//   buttons_in     in   raw pins, asynchronous to clk
//   event_clear    in   write-1-to-clear for event_pending, sampled each cycle
//   buttons        out  debounced levels, 1 = pressed
//   pressed        out  one-cycle press strobes
//   released       out  one-cycle release strobes
//   event_pending  out  sticky press events
//   irq            out  registered OR of event_pending
module button_conditioner
  import button_pkg::*;
#(
  parameter int BUTTONCOUNT     = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  input  logic [BUTTONCOUNT-1:0] event_clear,
  output logic [BUTTONCOUNT-1:0] buttons,
  output logic [BUTTONCOUNT-1:0] pressed,
  output logic [BUTTONCOUNT-1:0] released,
  output logic [BUTTONCOUNT-1:0] event_pending,
  output logic                   irq
);

  logic [BUTTONCOUNT-1:0] pend_q, pend_d;
  logic                   irq_q, irq_d;

  for (genvar g = 0; g < BUTTONCOUNT; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW != 0)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin_i      (buttons_in[g]),
      .level_o    (buttons[g]),
      .pressed_o  (pressed[g]),
      .released_o (released[g])
    );
  end

  // A press arriving together with a clear keeps the bit set.
  always_comb begin
    pend_d = (pend_q & ~event_clear) | pressed;
    irq_d  = |pend_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign event_pending = pend_q;
  assign irq           = irq_q;

endmodule
